// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding for the ALU logic datapath
package alu_pkg;
  localparam int OPW = 3;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_ANDN = 3'd4;
  localparam logic [2:0] OP_ORN  = 3'd5;
endpackage

// File: rtl/logic_array.sv
// logic_array: per-bit gate array selecting one bitwise op; undefined ops yield 0
module logic_array #(
  parameter int WIDTH = 32,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);
  import alu_pkg::*;
  logic w_and, w_or, w_xor, w_nor, w_andn, w_orn;
  assign w_and  = op == OPW'(OP_AND);
  assign w_or   = op == OPW'(OP_OR);
  assign w_xor  = op == OPW'(OP_XOR);
  assign w_nor  = op == OPW'(OP_NOR);
  assign w_andn = op == OPW'(OP_ANDN);
  assign w_orn  = op == OPW'(OP_ORN);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign res[i] = (w_and  & a[i] & b[i])
                  | (w_or   & (a[i] | b[i]))
                  | (w_xor  & (a[i] ^ b[i]))
                  | (w_nor  & ~(a[i] | b[i]))
                  | (w_andn & a[i] & ~b[i])
                  | (w_orn  & (a[i] | ~b[i]));
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined bitwise logic unit with zero and illegal-op flags
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             illegal
);
  import alu_pkg::*;
  logic             r_s1_valid, r_s2_valid;
  logic [OPW-1:0]   r_s1_op;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_res;
  logic             r_zero, r_illegal;
  logic             w_s1_adv, w_accept, w_illegal;
  logic [WIDTH-1:0] w_res;
  // S1 moves on whenever S2 is empty or draining; in_ready never looks at in_valid
  assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept = in_valid && in_ready;
  assign w_illegal = r_s1_op > OPW'(OP_ORN);
  logic_array #(.WIDTH(WIDTH), .OPW(OPW)) u_array (
    .op (r_s1_op),
    .a  (r_s1_a),
    .b  (r_s1_b),
    .res(w_res)
  );
  // Stage 1: capture operands on input handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= w_accept || (r_s1_valid && !w_s1_adv);
      if (w_accept) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end
  // Stage 2: capture result and flags when S1 advances, empty on consumer handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_res      <= w_res;
      r_zero     <= ~|w_res;
      r_illegal  <= w_illegal;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end
  assign out_valid = r_s2_valid;
  assign res       = r_res;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed plus random checks of logic_unit_pipe against a queue-based model
module tb_logic_unit_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [2:0]  op;
  logic [31:0] a, b, res;
  logic        v8, rdy8, ov8, or8, z8, il8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        v1, rdy1, ov1, or1, z1, il1;
  logic [2:0]  op1;
  logic [0:0]  a1, b1, res1;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        last_acc = 1'b0;
  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        il;
    int          avail;
  } item_t;
  item_t q[$];
  logic [31:0] sw [5] = '{32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000, 32'hF000_00F0, 32'hF0FF_F0FF};

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .zero(zero), .illegal(illegal));
  logic_unit_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .res(res8), .zero(z8), .illegal(il8));
  logic_unit_pipe #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .op(op1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .res(res1), .zero(z1), .illegal(il1));

  function automatic logic [63:0] f(input int o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x | y);
      4: return x & ~y;
      5: return x | ~y;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle: compare DUT with model, then advance model across the clock edge
  task automatic tick();
    logic  exp_rdy, exp_ov, acc, drn;
    item_t it;
    logic [63:0] t;
    #1;
    exp_rdy = (q.size() < 2) || out_ready;
    exp_ov  = (q.size() > 0) && (cyc >= q[0].avail);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("res", res, q[0].r);
      chk("zero", zero, q[0].z);
      chk("illegal", illegal, q[0].il);
    end
    acc = in_valid && exp_rdy;
    drn = exp_ov && out_ready;
    t = f(int'(op), 64'(a), 64'(b));
    it.r = t[31:0];
    it.z = (t[31:0] == 0);
    it.il = (op > 3'd5);
    @(posedge clk);
    cyc++;
    if (drn) begin
      void'(q.pop_front());
      if (q.size() > 0 && q[0].avail < cyc) q[0].avail = cyc;
    end
    if (acc) begin
      it.avail = cyc + 1;
      q.push_back(it);
    end
    last_acc = acc;
    #1;
  endtask

  initial begin
    logic [63:0] e;
    reset = 1'b1;
    in_valid = 0; op = 0; a = 0; b = 0; out_ready = 0;
    v8 = 0; op8 = 0; a8 = 0; b8 = 0; or8 = 1;
    v1 = 0; op1 = 0; a1 = 0; b1 = 0; or1 = 1;
    #22;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk); cyc++; #1;
    reset = 0;
    // single op, then idle until it emerges
    out_ready = 1;
    in_valid = 1; op = 3'd0; a = 32'hF0F0_00FF; b = 32'h0FF0_0F0F;
    tick();
    in_valid = 0;
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_res", res, 32'h00F0_000F);
    tick();
    tick();
    // op sweep at full throughput
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 5);
      op = 3'(k + 1);
      tick();
      if (k >= 1 && k <= 5) chk("sweep_res", res, sw[k-1]);
    end
    in_valid = 0;
    tick();
    // backpressure: three offered, two fit
    out_ready = 0;
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) op = 3'(k);
      tick();
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_res_held", res, 32'h00F0_000F);
    out_ready = 1;
    tick();
    in_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    // zero and illegal flags
    in_valid = 1; op = 3'd2; a = 32'h1234_5678; b = 32'h1234_5678;
    tick();
    op = 3'd7;
    tick();
    in_valid = 0;
    chk("xor_res", res, 0);
    chk("xor_zero", zero, 1);
    chk("xor_illegal", illegal, 0);
    tick();
    chk("ill_res", res, 0);
    chk("ill_zero", zero, 1);
    chk("ill_illegal", illegal, 1);
    tick();
    // reset in the middle of a stall
    out_ready = 0; in_valid = 1; op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h0;
    tick();
    op = 3'd5;
    tick();
    in_valid = 0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk); cyc++;
    #3 reset = 0;
    @(posedge clk); cyc++; #1;
    out_ready = 1;
    for (int k = 0; k < 3; k++) tick();
    // random traffic with producer hold rule
    for (int k = 0; k < 400; k++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    // narrow widths
    v8 = 1; op8 = 3'd3; a8 = 8'hA5; b8 = 8'h3C;
    @(posedge clk); #1 v8 = 0;
    @(posedge clk); #1;
    chk("w8_valid", ov8, 1);
    chk("w8_nor", res8, 8'h42);
    for (int o = 0; o < 8; o++) begin
      v8 = 1; op8 = 3'(o); a8 = 8'($urandom); b8 = 8'($urandom);
      v1 = 1; op1 = 3'(o); a1 = 1'($urandom); b1 = 1'($urandom);
      @(posedge clk); #1 v8 = 0; v1 = 0;
      @(posedge clk); #1;
      e = f(o, 64'(a8), 64'(b8)) & 64'hFF;
      chk("w8_res", res8, e);
      chk("w8_zero", z8, e == 0);
      chk("w8_illegal", il8, o > 5);
      e = f(o, 64'(a1), 64'(b1)) & 64'h1;
      chk("w1_res", res1, e);
      chk("w1_zero", z1, e == 0);
    end
    v1 = 1; op1 = 3'd4; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1 v1 = 0;
    @(posedge clk); #1;
    chk("w1_valid", ov1, 1);
    chk("w1_andn", res1, 0);
    chk("w1_andn_zero", z1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
